pma_region_table: RTL
=====================

PMA_REGION_TABLE -- requirements
Module: pma_region_table

Interface
REQ-001 SHALL have parameter NrRules, default 4, number of region rules (1..16).
REQ-002 SHALL have parameter AddrWidth, default 64, physical address width.
REQ-003 SHALL have parameter RstBase, default all-zero array [NrRules][AddrWidth], reset base per rule.
REQ-004 SHALL have parameter RstLength, default all-zero array [NrRules][AddrWidth], reset length per rule (0 = rule disabled).
REQ-005 SHALL have parameter RstAttr, default all-zero array [NrRules][3], reset attributes {nonidem, cached, exec}.
REQ-006 Port: clk_i  input  1  clock. One clock.
REQ-007 Port: rst_i  input  1  reset. Asynchronous, active-high.
REQ-008 Port: cfg_valid_i  input  1  shadow write request.
REQ-009 Port: cfg_ready_o  output  1  shadow write accepted when high with cfg_valid_i.
REQ-010 Port: cfg_idx_i  input  $clog2(NrRules) (min 1)  target rule.
REQ-011 Port: cfg_field_i  input  2  0 = base, 1 = length, 2 = attr, 3 = lock.
REQ-012 Port: cfg_wdata_i  input  AddrWidth  write data; attr uses bits [2:0], lock uses bit 0.
REQ-013 Port: cfg_err_o  output  1  one-cycle pulse on a rejected write.
REQ-014 Port: commit_i  input  1  copy shadow table to active table.
REQ-015 Port: req_valid_i  input  1  lookup request.
REQ-016 Port: req_addr_i  input  AddrWidth  lookup address.
REQ-017 Port: resp_valid_o  output  1  lookup result valid.
REQ-018 Port: resp_hit_o  output  1  address matched an enabled rule.
REQ-019 Port: resp_idx_o  output  $clog2(NrRules) (min 1)  matching rule index.
REQ-020 Port: resp_attr_o  output  3  {nonidem, cached, exec} of the matching rule; 0 on miss.

Function
REQ-021 SHALL hold two tables (shadow, active), each with per-rule base, length, attr and lock.
REQ-022 cfg_ready_o SHALL be high except in the cycle in which commit_i is sampled high.
REQ-023 An accepted write SHALL update the addressed shadow field at the next clock edge.
REQ-024 A write to a rule whose active lock bit is 1 SHALL be dropped and SHALL pulse cfg_err_o in the following cycle.
REQ-025 A write with cfg_idx_i >= NrRules, or with field 3 and wdata[0] = 0 on a locked rule, SHALL likewise be dropped and pulse cfg_err_o.
REQ-026 Lock SHALL be sticky: once active, it clears only on reset.
REQ-027 commit_i high SHALL copy every unlocked shadow rule into the active table at the next edge, atomically.
REQ-028 Locked active rules SHALL be unaffected by commit_i.
REQ-029 Lookup SHALL have a 1-cycle latency: resp_valid_o equals req_valid_i delayed one cycle. There is no backpressure.
REQ-030 Match condition: length != 0 and base <= addr and addr < base + length, computed in AddrWidth+1 bits, so a wrap past 2^AddrWidth extends to the top of the address space.
REQ-031 On multiple matches, the lowest index SHALL win.
REQ-032 On no match, resp_hit_o = 0, resp_idx_o = 0 and resp_attr_o = 0.
REQ-033 A lookup sampled in the same cycle as a commit SHALL use the pre-commit active table.
REQ-034 Response outputs SHALL hold their last value while resp_valid_o = 0.

Reset
REQ-035 While rst_i is high, both tables SHALL load RstBase/RstLength/RstAttr and all locks SHALL be 0.
REQ-036 While rst_i is high, resp_valid_o, resp_hit_o, resp_idx_o, resp_attr_o and cfg_err_o SHALL be 0, and cfg_ready_o SHALL be 1.
REQ-037 Reset asserted mid-operation SHALL discard pending shadow writes and any in-flight lookup response.

Verification
REQ-038 Reset with NrRules=4 and rule 0 = {base 0x8000_0000, len 0x4000_0000, attr 3'b011}; lookup 0x8000_0000 -> next cycle hit=1, idx=0, attr=011; lookup 0xC000_0000 -> hit=0, attr=000.
REQ-039 Shadow-write rule 1 to {base 0x1_0000, len 0x1_0000, attr 001} without commit; lookup 0x1_0004 -> miss. After commit, the same lookup -> hit, idx=1, attr=001.
REQ-040 Rules 0 and 2 overlapping at 0x1000 -> idx=0 reported.
REQ-041 Lock rule 0, then write rule 0 base -> cfg_err_o pulses one cycle. Commit with altered shadow rule 0 -> active rule 0 unchanged.
REQ-042 Rule with base 0xFFFF_FFFF_FFFF_F000 and len 0x2000 -> addr 0xFFFF_FFFF_FFFF_FFF8 hits; addr 0x0 misses.
REQ-043 Commit and lookup in the same cycle -> old result returned and cfg_ready_o low for that cycle. Reset asserted one cycle after req_valid_i -> resp_valid_o stays 0.

Source files
------------

// File: rtl/pma_region_table.sv
// pma_region_table
//   Physical-memory-attribute region table. A shadow table is written through
//   the cfg_* port and copied into the active table on commit_i. Lookups match
//   against the active table with one cycle of latency; the lowest matching
//   rule index wins. Locked active rules are frozen until reset.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   cfg_valid_i/ready_o shadow write handshake (ready low only while committing)
//   cfg_idx_i           target rule
//   cfg_field_i         0 base, 1 length, 2 attr, 3 lock
//   cfg_wdata_i         write data (attr in [2:0], lock in [0])
//   cfg_err_o           one-cycle pulse after a rejected write
//   commit_i            copy unlocked shadow rules into the active table
//   req_valid_i/addr_i  lookup request
//   resp_*              registered lookup result {hit, idx, attr}
module pma_region_table #(
    parameter int unsigned NrRules   = 4,
    parameter int unsigned AddrWidth = 64,
    parameter logic [NrRules-1:0][AddrWidth-1:0] RstBase   = '0,
    parameter logic [NrRules-1:0][AddrWidth-1:0] RstLength = '0,
    parameter logic [NrRules-1:0][2:0]           RstAttr   = '0,
    localparam int unsigned IdxW = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [IdxW-1:0]      cfg_idx_i,
    input  logic [1:0]           cfg_field_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic                 cfg_err_o,
    input  logic                 commit_i,
    input  logic                 req_valid_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 resp_valid_o,
    output logic                 resp_hit_o,
    output logic [IdxW-1:0]      resp_idx_o,
    output logic [2:0]           resp_attr_o
);

    logic [AddrWidth-1:0] shd_base_q [NrRules];
    logic [AddrWidth-1:0] shd_base_d [NrRules];
    logic [AddrWidth-1:0] shd_len_q  [NrRules];
    logic [AddrWidth-1:0] shd_len_d  [NrRules];
    logic [2:0]           shd_attr_q [NrRules];
    logic [2:0]           shd_attr_d [NrRules];
    logic [NrRules-1:0]   shd_lock_q, shd_lock_d;

    logic [AddrWidth-1:0] act_base_q [NrRules];
    logic [AddrWidth-1:0] act_base_d [NrRules];
    logic [AddrWidth-1:0] act_len_q  [NrRules];
    logic [AddrWidth-1:0] act_len_d  [NrRules];
    logic [2:0]           act_attr_q [NrRules];
    logic [2:0]           act_attr_d [NrRules];
    logic [NrRules-1:0]   act_lock_q, act_lock_d;

    logic                 cfg_err_q, cfg_err_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_hit_q, resp_hit_d;
    logic [IdxW-1:0]      resp_idx_q, resp_idx_d;
    logic [2:0]           resp_attr_q, resp_attr_d;

    logic                 wr_en, wr_bad, idx_ok, tgt_act_lock, tgt_shd_lock;
    logic                 hit;
    logic [IdxW-1:0]      hit_idx;
    logic [2:0]           hit_attr;
    logic [AddrWidth:0]   lim;

    // Configuration: shadow writes and commit into the active table.
    always_comb begin
        cfg_ready_o  = !commit_i;
        wr_en        = cfg_valid_i && !commit_i;
        idx_ok       = 32'(cfg_idx_i) < NrRules;
        tgt_act_lock = 1'b0;
        tgt_shd_lock = 1'b0;
        for (int unsigned i = 0; i < NrRules; i++) begin
            if (32'(cfg_idx_i) == i) begin
                tgt_act_lock = act_lock_q[i];
                tgt_shd_lock = shd_lock_q[i];
            end
        end
        // Clearing a lock that is already set in the shadow is refused too,
        // so a staged lock cannot be silently withdrawn.
        wr_bad = !idx_ok || tgt_act_lock ||
                 (cfg_field_i == 2'd3 && !cfg_wdata_i[0] && tgt_shd_lock);
        cfg_err_d = wr_en && wr_bad;

        shd_lock_d = shd_lock_q;
        act_lock_d = act_lock_q;
        for (int unsigned i = 0; i < NrRules; i++) begin
            shd_base_d[i] = shd_base_q[i];
            shd_len_d[i]  = shd_len_q[i];
            shd_attr_d[i] = shd_attr_q[i];
            act_base_d[i] = act_base_q[i];
            act_len_d[i]  = act_len_q[i];
            act_attr_d[i] = act_attr_q[i];
            if (wr_en && !wr_bad && 32'(cfg_idx_i) == i) begin
                case (cfg_field_i)
                    2'd0:    shd_base_d[i] = cfg_wdata_i;
                    2'd1:    shd_len_d[i]  = cfg_wdata_i;
                    2'd2:    shd_attr_d[i] = cfg_wdata_i[2:0];
                    default: shd_lock_d[i] = cfg_wdata_i[0];
                endcase
            end
            // A locked active rule never changes, which also keeps its lock set.
            if (commit_i && !act_lock_q[i]) begin
                act_base_d[i] = shd_base_q[i];
                act_len_d[i]  = shd_len_q[i];
                act_attr_d[i] = shd_attr_q[i];
                act_lock_d[i] = shd_lock_q[i];
            end
        end
    end

    // Lookup against the current active table; scanning downward lets the
    // lowest matching index overwrite any higher one.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_attr = '0;
        lim      = '0;
        for (int i = int'(NrRules) - 1; i >= 0; i--) begin
            // One extra bit so a region running past the top does not wrap.
            lim = {1'b0, act_base_q[i]} + {1'b0, act_len_q[i]};
            if (act_len_q[i] != '0 && req_addr_i >= act_base_q[i] &&
                {1'b0, req_addr_i} < lim) begin
                hit      = 1'b1;
                hit_idx  = IdxW'(i);
                hit_attr = act_attr_q[i];
            end
        end
        resp_valid_d = req_valid_i;
        resp_hit_d   = resp_hit_q;
        resp_idx_d   = resp_idx_q;
        resp_attr_d  = resp_attr_q;
        if (req_valid_i) begin
            resp_hit_d  = hit;
            resp_idx_d  = hit_idx;
            resp_attr_d = hit_attr;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NrRules; i++) begin
                shd_base_q[i] <= RstBase[i];
                shd_len_q[i]  <= RstLength[i];
                shd_attr_q[i] <= RstAttr[i];
                act_base_q[i] <= RstBase[i];
                act_len_q[i]  <= RstLength[i];
                act_attr_q[i] <= RstAttr[i];
            end
            shd_lock_q   <= '0;
            act_lock_q   <= '0;
            cfg_err_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_idx_q   <= '0;
            resp_attr_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < NrRules; i++) begin
                shd_base_q[i] <= shd_base_d[i];
                shd_len_q[i]  <= shd_len_d[i];
                shd_attr_q[i] <= shd_attr_d[i];
                act_base_q[i] <= act_base_d[i];
                act_len_q[i]  <= act_len_d[i];
                act_attr_q[i] <= act_attr_d[i];
            end
            shd_lock_q   <= shd_lock_d;
            act_lock_q   <= act_lock_d;
            cfg_err_q    <= cfg_err_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_idx_q   <= resp_idx_d;
            resp_attr_q  <= resp_attr_d;
        end
    end

    assign cfg_err_o    = cfg_err_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_hit_o   = resp_hit_q;
    assign resp_idx_o   = resp_idx_q;
    assign resp_attr_o  = resp_attr_q;

endmodule
